reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- LC-3 general-purpose register file: eight 16-bit registers R0–R7.
- One synchronous write port and two combinational read ports (SR1 and SR2).
- Sits in the datapath between the bus/ALU result (write data) and the ALU operand inputs.
- The control unit drives the write register select (DR), the write enable (LD.REG) and the read selects.

Parameters:
- DATA_W, 16, width of each register and of all data ports.
- ADDR_W, 3, width of register select fields.
- NUM_REGS = 2**ADDR_W (8); derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ld_reg  input  1  write enable (LD.REG); write occurs only when high at a rising clk edge.
- write_reg  input  ADDR_W  destination register select (DR).
- indata  input  DATA_W  write data.
- out_reg  input  ADDR_W  read port 1 select (SR1).
- outdata  output  DATA_W  read port 1 data.
- out_reg2  input  ADDR_W  read port 2 select (SR2).
- outdata2  output  DATA_W  read port 2 data.

Behaviour:
- Reset:
  - rst_n low clears all eight registers to 16'h0000 immediately, with no clock needed.
  - While rst_n is low, outdata and outdata2 read 16'h0000.
  - Writes are ignored while rst_n is low.
  - Deassertion takes effect at the next rising edge.
- Write:
  - On a rising clk edge with rst_n high and ld_reg high, indata is stored into R[write_reg].
  - No other register changes.
  - ld_reg low: all registers hold.
- Read:
  - outdata = R[out_reg] and outdata2 = R[out_reg2]; purely combinational, zero-cycle latency from select change.
- Write-to-read ordering:
  - No write-through bypass.
  - When a read select equals write_reg during a write cycle, the output shows the old value until the clock edge, then the new value (one-cycle visibility latency).
- Both read ports may select the same register; both then show identical data.
- All register indices 0–7 are valid. There is no out-of-range case, no wrap logic and no X output for any select value.
- Reset mid-operation: an asynchronous clear overrides any write pending on the same edge.
- Data is stored verbatim; no sign extension or condition-code generation here (NZP logic lives outside).

Decomposition:
- Shared package lc3_pkg:
  - DATA_W = 16 and REG_ADDR_W = 3 constants.
  - typedef word_t (logic [15:0]).
  - typedef reg_idx_t (logic [2:0]).
- No sub-module needed.
- Storage is a single array of NUM_REGS words.
- The read muxes are two continuous index selects.

Test Plan:
- Reset: pulse rst_n low mid-cycle with prior contents nonzero -> all outputs read 0x0000 immediately for every out_reg 0–7.
- Write each register with its index:
  - Stimulus: ld_reg=1, write_reg=i, indata=i for i=0..7, one per cycle.
  - Response: after each edge, outdata with out_reg=i reads i.
  - Response: before the edge, it shows the previous value (no bypass).
- Hold state: after loading R0..R7=0..7, set ld_reg=0, indata=0xFFFF, toggle write_reg for 4 cycles -> sweeping out_reg 0..7 returns 0..7 unchanged.
- Dual read: R3=0x1234 and R5=0xBEEF -> out_reg=3 and out_reg2=5 give 0x1234/0xBEEF; out_reg=out_reg2=5 gives 0xBEEF on both.
- Overwrite/isolation: write R7=0xFFFF, then R7=0x8000 -> R7 reads 0x8000 and R6 is unchanged.
- Async reset overrides a write: assert rst_n low coincident with a write edge (ld_reg=1, R2, 0xAAAA) -> R2 reads 0x0000.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath constants and types: word width and register index width.
package lc3_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef logic [DATA_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file.sv
// LC-3 general-purpose register file: eight words, one clocked write port,
// two combinational read ports with no write-through bypass.
module reg_file #(
    parameter int DATA_W = lc3_pkg::DATA_W,
    parameter int ADDR_W = lc3_pkg::REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_reg,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] indata,
    input  logic [ADDR_W-1:0] out_reg,
    output logic [DATA_W-1:0] outdata,
    input  logic [ADDR_W-1:0] out_reg2,
    output logic [DATA_W-1:0] outdata2
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] reg_mem [NUM_REGS];

    // The clear is asynchronous, so a write landing on the same edge as a
    // reset assertion is lost; reads also see zero for as long as rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_mem[i] <= '0;
            end
        end else if (ld_reg) begin
            reg_mem[write_reg] <= indata;
        end
    end

    // Every select value addresses a real register, so no range guard is needed.
    assign outdata  = reg_mem[out_reg];
    assign outdata2 = reg_mem[out_reg2];

endmodule

// File: tb/tb_reg_file.sv
// Directed plus randomized checks of reg_file against an array model of R0..R7.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        ld_reg;
    logic [2:0]  write_reg;
    logic [15:0] indata;
    logic [2:0]  out_reg;
    logic [15:0] outdata;
    logic [2:0]  out_reg2;
    logic [15:0] outdata2;

    logic [15:0] model [8];
    int vectors;
    int miscompares;

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_reg    (ld_reg),
        .write_reg (write_reg),
        .indata    (indata),
        .out_reg   (out_reg),
        .outdata   (outdata),
        .out_reg2  (out_reg2),
        .outdata2  (outdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    endtask

    // Read both ports of every register combinationally and compare to the model.
    task automatic sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            out_reg  = 3'(i);
            out_reg2 = 3'(7 - i);
            #1;
            check($sformatf("%s_p1_r%0d", tag, i), outdata, model[i]);
            check($sformatf("%s_p2_r%0d", tag, 7 - i), outdata2, model[7 - i]);
        end
    endtask

    // One write cycle: check the old value before the edge and the new one after.
    task automatic write_cycle(input logic [2:0] wr, input logic [15:0] data, input string tag);
        @(negedge clk);
        ld_reg    = 1'b1;
        write_reg = wr;
        indata    = data;
        out_reg   = wr;
        #1;
        check($sformatf("%s_pre", tag), outdata, model[wr]);
        @(posedge clk);
        #1;
        model[wr] = data;
        check($sformatf("%s_post", tag), outdata, data);
        @(negedge clk);
        ld_reg = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_model();
        rst_n     = 1'b0;
        ld_reg    = 1'b1;
        write_reg = 3'd4;
        indata    = 16'h5555;
        out_reg   = 3'd0;
        out_reg2  = 3'd0;

        // Reset held across edges with a write requested: everything reads zero.
        repeat (2) @(posedge clk);
        #1;
        sweep("reset_hold");
        @(negedge clk);
        ld_reg = 1'b0;
        rst_n  = 1'b1;

        for (int i = 0; i < 8; i++) write_cycle(3'(i), 16'(i), $sformatf("wr_idx%0d", i));

        // Mid-cycle asynchronous reset with nonzero contents.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        sweep("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) write_cycle(3'(i), 16'(i), $sformatf("reload%0d", i));

        // Hold: ld_reg low with junk data and a moving write select.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ld_reg    = 1'b0;
            indata    = 16'hFFFF;
            write_reg = 3'(c * 3);
        end
        @(negedge clk);
        sweep("hold");

        write_cycle(3'd3, 16'h1234, "dual_w3");
        write_cycle(3'd5, 16'hBEEF, "dual_w5");
        out_reg  = 3'd3;
        out_reg2 = 3'd5;
        #1;
        check("dual_p1", outdata, 16'h1234);
        check("dual_p2", outdata2, 16'hBEEF);
        out_reg = 3'd5;
        #1;
        check("same_p1", outdata, 16'hBEEF);
        check("same_p2", outdata2, 16'hBEEF);

        write_cycle(3'd7, 16'hFFFF, "ovr_a");
        write_cycle(3'd7, 16'h8000, "ovr_b");
        out_reg  = 3'd7;
        out_reg2 = 3'd6;
        #1;
        check("ovr_r7", outdata, 16'h8000);
        check("ovr_r6", outdata2, 16'h0006);

        // Randomized traffic against the model, checking both ports before and after each edge.
        for (int n = 0; n < 300; n++) begin
            logic        ld;
            logic [2:0]  wr;
            logic [15:0] d;
            @(negedge clk);
            ld        = 1'($urandom_range(0, 1));
            wr        = 3'($urandom_range(0, 7));
            d         = 16'($urandom);
            ld_reg    = ld;
            write_reg = wr;
            indata    = d;
            out_reg   = ($urandom_range(0, 3) == 0) ? wr : 3'($urandom_range(0, 7));
            out_reg2  = 3'($urandom_range(0, 7));
            #1;
            check("rnd_pre_p1", outdata, model[out_reg]);
            check("rnd_pre_p2", outdata2, model[out_reg2]);
            @(posedge clk);
            #1;
            if (ld) model[wr] = d;
            check("rnd_post_p1", outdata, model[out_reg]);
            check("rnd_post_p2", outdata2, model[out_reg2]);
        end
        @(negedge clk);
        ld_reg = 1'b0;
        sweep("rnd_final");

        // Reset asserted at the same edge as a write to R2.
        write_cycle(3'd2, 16'h1111, "pre_rst_w2");
        @(negedge clk);
        ld_reg    = 1'b1;
        write_reg = 3'd2;
        indata    = 16'hAAAA;
        @(posedge clk);
        rst_n = 1'b0;
        clear_model();
        #1;
        out_reg = 3'd2;
        #1;
        check("rst_vs_write_r2", outdata, 16'h0000);
        sweep("rst_vs_write");
        @(negedge clk);
        ld_reg = 1'b0;
        rst_n  = 1'b1;

        // Deassertion: first write after reset lands normally.
        write_cycle(3'd1, 16'hC0DE, "post_rst_w1");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
